conv1_w_loader: RTL and testbench



---
 rtl/conv1_w_loader.sv | 98 +++++++++
 tb/tb_conv1_w_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/conv1_w_loader.sv
// Runtime loader for the conv1 weight store: scatters a valid/ready byte stream
// into a registered [filter][row][col] array and flags when the set is complete.
module conv1_w_loader #(
  parameter int NUM_FILTERS = 16,
  parameter int K           = 3,
  parameter int WIDTH       = 8
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  start,
  input  logic                                                  s_valid,
  input  logic [WIDTH-1:0]                                      s_data,
  output logic                                                  s_ready,
  output logic                                                  busy,
  output logic                                                  done,
  output logic                                                  loaded,
  output logic signed [NUM_FILTERS-1:0][K-1:0][K-1:0][WIDTH-1:0] weights
);

  localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t                                               state_q;
  logic [FW-1:0]                                        f_q;
  logic [KW-1:0]                                        i_q, j_q;
  logic                                                 ready_q, busy_q, done_q, loaded_q;
  logic [NUM_FILTERS-1:0][K-1:0][K-1:0][WIDTH-1:0]      w_q;

  wire last_j = (j_q == KW'(K - 1));
  wire last_i = (i_q == KW'(K - 1));
  wire last_f = (f_q == FW'(NUM_FILTERS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      f_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      loaded_q <= 1'b0;
      w_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_LOAD;
            f_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            loaded_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        S_LOAD: begin
          if (s_valid) begin
            w_q[f_q][i_q][j_q] <= s_data;
            // Nested j -> i -> f counters replace a divide by K*K.
            if (!last_j) begin
              j_q <= j_q + KW'(1);
            end else begin
              j_q <= '0;
              if (!last_i) begin
                i_q <= i_q + KW'(1);
              end else begin
                i_q <= '0;
                if (!last_f) begin
                  f_q <= f_q + FW'(1);
                end else begin
                  f_q      <= '0;
                  state_q  <= S_DONE;
                  ready_q  <= 1'b0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  loaded_q <= 1'b1;
                end
              end
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s_ready = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign loaded  = loaded_q;
  assign weights = w_q;

endmodule

// File: tb/tb_conv1_w_loader.sv
// Directed bench for conv1_w_loader: a driver issues weight streams and queues
// the expected array; a monitor checks each done pulse against the queue.
module tb_conv1_w_loader;
  localparam int NF = 16;
  localparam int K  = 3;
  localparam int W  = 8;
  localparam int N  = NF * K * K;

  logic clk = 1'b0;
  logic reset, start, s_valid;
  logic [W-1:0] s_data;
  logic s_ready, busy, done, loaded;
  logic signed [NF-1:0][K-1:0][K-1:0][W-1:0] weights;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0][W-1:0] w;
    int                  cyc;   // expected LOAD cycles, 0 = don't care
  } exp_t;
  exp_t sbq[$];

  int acc_cnt = 0;
  int ld_cyc  = 0;

  always #5 clk = ~clk;

  conv1_w_loader #(.NUM_FILTERS(NF), .K(K), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .busy(busy), .done(done), .loaded(loaded), .weights(weights)
  );

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pat(input int mode, input int n);
    case (mode)
      2:       return (n % 2 == 0) ? 8'h7F : 8'h80;
      3:       return 8'(255 - n);
      default: return 8'(n);
    endcase
  endfunction

  // Monitor: counts LOAD cycles and accepts, checks the array on every done.
  always @(negedge clk) begin
    exp_t e;
    int   bad, first;
    if (reset) begin
      acc_cnt = 0;
      ld_cyc  = 0;
    end else begin
      if (s_ready) ld_cyc++;
      if (s_valid && s_ready) acc_cnt++;
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          bad = 0; first = -1;
          for (int f = 0; f < NF; f++)
            for (int i = 0; i < K; i++)
              for (int j = 0; j < K; j++)
                if (weights[f][i][j] !== e.w[f*K*K + i*K + j]) begin
                  if (first < 0) first = f*K*K + i*K + j;
                  bad++;
                end
          if (bad != 0)
            $display("FAIL array_entry: first bad index %0d got %0h expected %0h",
                     first, weights[first/9][(first%9)/3][first%3], e.w[first]);
          chk("array_mismatches", bad, 0);
          chk("loaded_at_done", loaded, 1);
          chk("ready_at_done", s_ready, 0);
          chk("busy_at_done", busy, 0);
          chk("accept_count", acc_cnt, N);
          if (e.cyc > 0) chk("load_cycles", ld_cyc, e.cyc);
        end
        acc_cnt = 0;
        ld_cyc  = 0;
      end
    end
  end

  // Drive one stream; stop_at < N leaves the load incomplete.
  task automatic load(input int mode, input bit gaps, input bit pokes, input int stop_at);
    exp_t e;
    bit   acc;
    int   t;
    for (int n = 0; n < N; n++) e.w[n] = pat(mode, n);
    e.cyc = gaps ? 0 : N;
    if (stop_at == N) sbq.push_back(e);
    // start with s_valid high: this byte must not be taken
    start = 1'b1; s_valid = 1'b1; s_data = 8'hEE;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ready_after_start", s_ready, 1);
    chk("busy_after_start", busy, 1);
    chk("loaded_cleared", loaded, 0);
    for (int n = 0; n < stop_at; n++) begin
      acc = 1'b0; t = 0;
      s_data = pat(mode, n);
      if (pokes) start = (n == 20);
      while (!acc && t < 64) begin
        s_valid = gaps ? 1'($urandom % 2) : 1'b1;
        @(negedge clk);
        acc = s_valid && s_ready;
        @(posedge clk); #1;
        t++;
      end
      start = 1'b0;
      if (!acc) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    s_valid = 1'b0;
    if (pokes) begin
      start = 1'b1;                 // lands on the DONE cycle
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      chk("start_in_done_ignored", s_ready, 0);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 8) begin
      @(posedge clk); #1;
      t++;
    end
    chk("scoreboard_drained", sbq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_weights", |weights, 0);
    reset = 1'b0;

    // s_valid in IDLE writes nothing
    s_valid = 1'b1; s_data = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_write", |weights, 0);
    chk("idle_ready", s_ready, 0);
    s_valid = 1'b0;

    // back-to-back ramp 0x00..0x8F
    load(0, 1'b0, 1'b0, N);
    drain();
    chk("ramp_000", weights[0][0][0], 0);
    chk("ramp_100", weights[1][0][0], 9);
    chk("ramp_312", weights[3][1][2], 32);
    chk("ramp_f22", weights[15][2][2], 143);
    chk("ramp_loaded", loaded, 1);

    // random gaps plus start pokes during LOAD and DONE
    load(0, 1'b1, 1'b1, N);
    drain();

    // signed extremes
    load(2, 1'b0, 1'b0, N);
    drain();
    chk("sgn_000", $signed(weights[0][0][0]), 127);
    chk("sgn_001", $signed(weights[0][0][1]), -128);
    chk("sgn_f21", $signed(weights[15][2][1]), 127);
    chk("sgn_f22", $signed(weights[15][2][2]), -128);

    // reset after 50 accepts
    load(0, 1'b0, 1'b0, 50);
    reset = 1'b1;
    #1;
    chk("midrst_ready", s_ready, 0);
    chk("midrst_loaded", loaded, 0);
    chk("midrst_done", done, 0);
    chk("midrst_weights", |weights, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    load(0, 1'b0, 1'b0, N);
    drain();

    // reload over a loaded set with different values
    load(3, 1'b0, 1'b0, N);
    drain();
    chk("reload_000", $signed(weights[0][0][0]), -1);
    chk("reload_f22", weights[15][2][2], 8'h70);

    repeat (3) @(posedge clk);
    #1;
    chk("final_idle_ready", s_ready, 0);
    chk("final_queue", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
